// File: rtl/fitness_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fitness_pkg
// Description : FSM state type and width helpers for fitness_knapsack_eval.
// Revision    : 1.0 - initial release
// ============================================================================
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int gene_num);
    return (gene_num > 1) ? $clog2(gene_num) : 1;
  endfunction

  function automatic int sum_w(input int val_w, input int gene_num);
    return val_w + idx_w(gene_num);
  endfunction

  function automatic int wsum_w(input int wt_w, input int gene_num);
    return wt_w + idx_w(gene_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gene_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module      : gene_idx_cnt
// Description : Gene index counter; clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module gene_idx_cnt #(
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_o <= '0;
    end else if (clr_i) begin
      idx_o <= '0;
    end else if (en_i) begin
      idx_o <= idx_o + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fitness_knapsack_eval.sv
`default_nettype none
// ============================================================================
// Module      : fitness_knapsack_eval
// Description : Walks one chromosome per transaction, accumulates selected
//               item value/weight and returns a knapsack fitness score.
//               Optional macro KNAPSACK_PENALTY_EN: overweight solutions are
//               penalised by the excess weight instead of scoring zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fitness_knapsack_eval
  import fitness_pkg::*;
#(
  parameter  int          GENE_NUM = 8,
  parameter  int          VAL_W    = 8,
  parameter  int          WT_W     = 8,
  parameter  int unsigned CAPACITY = 100,
  localparam int          IDX_W    = idx_w(GENE_NUM),
  localparam int          SUM_W    = sum_w(VAL_W, GENE_NUM),
  localparam int          WSUM_W   = wsum_w(WT_W, GENE_NUM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [GENE_NUM-1:0] chrom_i,
  input  logic                chrom_valid_i,
  output logic                chrom_ready_o,
  input  logic                flush_i,
  output logic [IDX_W-1:0]    gene_idx_o,
  input  logic [VAL_W-1:0]    gene_val_i,
  input  logic [WT_W-1:0]     gene_wt_i,
  output logic [SUM_W-1:0]    fit_o,
  output logic                fit_valid_o,
  input  logic                fit_ready_i,
  output logic                busy_o
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GENE_NUM-1:0] r_chrom;
  logic [SUM_W-1:0]    r_val_sum;
  logic [WSUM_W-1:0]   r_wt_sum;
  logic [SUM_W-1:0]    r_fit;
  logic [SUM_W-1:0]    w_val_nxt;
  logic [WSUM_W-1:0]   w_wt_nxt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_last;
  logic                w_accept;
  logic                w_cnt_en;
  logic                w_cnt_clr;

  function automatic logic [SUM_W-1:0] calc_fit(input logic [SUM_W-1:0]  v,
                                                input logic [WSUM_W-1:0] w);
`ifdef KNAPSACK_PENALTY_EN
    localparam int EXT_W = (SUM_W > WSUM_W) ? SUM_W : WSUM_W;
    logic [EXT_W-1:0] v_ext;
    logic [EXT_W-1:0] over;
`endif
    if (w <= WSUM_W'(CAPACITY)) begin
      return v;
    end
`ifdef KNAPSACK_PENALTY_EN
    v_ext = EXT_W'(v);
    over  = EXT_W'(w) - EXT_W'(CAPACITY);
    return (v_ext > over) ? SUM_W'(v_ext - over) : '0;
`else
    return '0;
`endif
  endfunction

  gene_idx_cnt #(
    .IDX_W (IDX_W)
  ) u_gene_idx_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_cnt_en),
    .clr_i (w_cnt_clr),
    .idx_o (w_idx)
  );

  assign w_accept  = (r_state == IDLE) && chrom_valid_i;
  assign w_last    = (w_idx == IDX_W'(GENE_NUM - 1));
  assign w_cnt_en  = (r_state == EVAL);
  assign w_cnt_clr = flush_i || w_accept || ((r_state == EVAL) && w_last);

  // Only selected genes contribute; ROM data is valid in the same cycle
  assign w_val_nxt = r_val_sum + (r_chrom[w_idx] ? SUM_W'(gene_val_i) : '0);
  assign w_wt_nxt  = r_wt_sum  + (r_chrom[w_idx] ? WSUM_W'(gene_wt_i) : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (chrom_valid_i) w_state_nxt = EVAL;
      EVAL:    if (w_last)        w_state_nxt = DONE;
      DONE:    if (fit_ready_i)   w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chrom   <= '0;
      r_val_sum <= '0;
      r_wt_sum  <= '0;
      r_fit     <= '0;
    end else if (flush_i) begin
      r_val_sum <= '0;
      r_wt_sum  <= '0;
    end else if (w_accept) begin
      r_chrom   <= chrom_i;
      r_val_sum <= '0;
      r_wt_sum  <= '0;
    end else if (r_state == EVAL) begin
      r_val_sum <= w_val_nxt;
      r_wt_sum  <= w_wt_nxt;
      if (w_last) begin
        r_fit <= calc_fit(w_val_nxt, w_wt_nxt);
      end
    end
  end

  assign chrom_ready_o = (r_state == IDLE);
  assign fit_valid_o   = (r_state == DONE);
  assign busy_o        = (r_state != IDLE);
  assign fit_o         = r_fit;
  assign gene_idx_o    = (r_state == EVAL) ? w_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_fitness_knapsack_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_fitness_knapsack_eval
// Description : Self-checking bench for fitness_knapsack_eval (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fitness_knapsack_eval;

  localparam int GN = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  chrom_i = '0;
  logic        chrom_valid_i = 1'b0;
  logic        chrom_ready_o;
  logic        flush_i = 1'b0;
  logic [2:0]  gene_idx_o;
  logic [7:0]  gene_val_i;
  logic [7:0]  gene_wt_i;
  logic [10:0] fit_o;
  logic        fit_valid_o;
  logic        fit_ready_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  fitness_knapsack_eval dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .chrom_i       (chrom_i),
    .chrom_valid_i (chrom_valid_i),
    .chrom_ready_o (chrom_ready_o),
    .flush_i       (flush_i),
    .gene_idx_o    (gene_idx_o),
    .gene_val_i    (gene_val_i),
    .gene_wt_i     (gene_wt_i),
    .fit_o         (fit_o),
    .fit_valid_o   (fit_valid_o),
    .fit_ready_i   (fit_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Item ROM: value = 10(i+1), weight = 5(i+1)
  always_comb begin
    gene_val_i = 8'((int'(gene_idx_o) + 1) * 10);
    gene_wt_i  = 8'((int'(gene_idx_o) + 1) * 5);
  end

  function automatic int ref_fit(input logic [7:0] c);
    int v = 0;
    int w = 0;
    for (int i = 0; i < GN; i++) begin
      if (c[i]) begin
        v += 10 * (i + 1);
        w += 5 * (i + 1);
      end
    end
    if (w <= 100) return v;
`ifdef KNAPSACK_PENALTY_EN
    return (v > (w - 100)) ? v - (w - 100) : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] c, input int hold, input bit junk, input string tag);
    int n;
    int exp;
    exp = ref_fit(c);
    chrom_i       = c;
    chrom_valid_i = 1'b1;
    check({tag, "_ready"}, chrom_ready_o, 1);
    tick();
    chrom_valid_i = 1'b0;
    n = 0;
    while (!fit_valid_o && n < 40) begin
      if (n < GN) check({tag, "_idx"}, gene_idx_o, n);
      if (junk) begin
        chrom_i       = 8'($urandom);
        chrom_valid_i = 1'($urandom);
      end
      tick();
      n++;
    end
    chrom_valid_i = 1'b0;
    check({tag, "_latency"}, n, GN);
    check({tag, "_fit"}, fit_o, exp);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_ready_done"}, chrom_ready_o, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_fit"}, fit_o, exp);
      check({tag, "_hold_valid"}, fit_valid_o, 1);
      check({tag, "_hold_ready"}, chrom_ready_o, 0);
    end
    fit_ready_i = 1'b1;
    tick();
    fit_ready_i = 1'b0;
    check({tag, "_post_valid"}, fit_valid_o, 0);
    check({tag, "_post_busy"}, busy_o, 0);
  endtask

  initial begin
    bit seen_valid;

    // Asynchronous reset applied between clock edges
    #2 rst_i = 1'b1;
    #1;
    check("rst_ready", chrom_ready_o, 1);
    check("rst_valid", fit_valid_o, 0);
    check("rst_fit", fit_o, 0);
    check("rst_idx", gene_idx_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    run_txn(8'h05, 0, 1'b0, "h05");
    run_txn(8'h9C, 0, 1'b0, "h9c_cap");
    run_txn(8'hFF, 5, 1'b0, "hff_bp");
    run_txn(8'h00, 0, 1'b0, "h00_b2b");

    // Flush at gene index 3
    chrom_i       = 8'h05;
    chrom_valid_i = 1'b1;
    tick();
    chrom_valid_i = 1'b0;
    repeat (3) tick();
    check("flush_idx3", gene_idx_o, 3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_ready", chrom_ready_o, 1);
    check("flush_busy", busy_o, 0);
    check("flush_idx", gene_idx_o, 0);
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (fit_valid_o) seen_valid = 1'b1;
    end
    check("flush_no_valid", seen_valid, 0);
    run_txn(8'h05, 0, 1'b0, "post_flush");

    // Reset mid-EVAL: outputs must drop without a clock edge
    chrom_i       = 8'hFF;
    chrom_valid_i = 1'b1;
    tick();
    chrom_valid_i = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_ready", chrom_ready_o, 1);
    check("mid_rst_valid", fit_valid_o, 0);
    check("mid_rst_fit", fit_o, 0);
    check("mid_rst_idx", gene_idx_o, 0);
    check("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    run_txn(8'h9C, 0, 1'b0, "post_rst");

    // Random chromosomes with random backpressure and ignored offers mid-EVAL
    for (int t = 0; t < 12; t++) begin
      run_txn(8'($urandom), int'($urandom_range(0, 3)), 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
